axi_slave_ram: RTL

- AXI4 full-protocol responder backed by an internal byte-strobed RAM; the target end of the DDR AXI write/read masters.
- Used in simulation and bring-up in place of the MIG DDR core. The DDR control path is exercised end-to-end (ping-pong frame buffers, burst lengths up to 256) without external memory.
- One outstanding write burst and one outstanding read burst; the read and write channels run concurrently and independently.

---
 rtl/axi_slave_pkg.sv | 18 +
 rtl/axi_ram_bytewe.sv | 39 +++
 rtl/axi_slave_ram.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI4 slave RAM: response codes and FSM state types.
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi_ram_bytewe.sv
// Dual-port RAM: one byte-enabled write port, one synchronous read-first read port.
module axi_ram_bytewe #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4096,
  localparam int AW    = $clog2(DEPTH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write port; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && wbe[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Output register only loads on re, so it holds the beat during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 responder backed by a byte-strobed RAM; one write and one read burst in flight,
// channels independent.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int         AXI_WIDTH   = 256,
  parameter logic [2:0] AXI_AXSIZE  = 3'b101,
  parameter int         AXI_WSTRB_W = AXI_WIDTH >> 3,
  parameter int         ADDR_W      = 29,
  parameter int         MEM_DEPTH   = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             s_axi_awid,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic [2:0]             s_axi_awsize,
  input  logic [1:0]             s_axi_awburst,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [AXI_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_WSTRB_W-1:0] s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [3:0]             s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [3:0]             s_axi_arid,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic [7:0]             s_axi_arlen,
  input  logic [2:0]             s_axi_arsize,
  input  logic [1:0]             s_axi_arburst,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [3:0]             s_axi_rid,
  output logic [AXI_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Only INCR bursts are supported, so the burst type is deliberately dropped.
  logic unused_s;
  assign unused_s = ^{s_axi_awburst, s_axi_arburst};

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> AXI_AXSIZE);
  endfunction

  w_state_t         w_state_r, w_state_s;
  logic [3:0]       w_id_r;
  logic [IDX_W-1:0] w_idx_r;
  logic [7:0]       w_len_r, w_cnt_r;
  logic             w_err_r;
  logic             aw_hs_s, w_hs_s, b_hs_s, w_beat_last_s, w_final_s, w_err_s;

  assign aw_hs_s       = s_axi_awvalid & s_axi_awready;
  assign w_hs_s        = s_axi_wvalid & s_axi_wready;
  assign b_hs_s        = s_axi_bvalid & s_axi_bready;
  assign w_beat_last_s = (w_cnt_r == w_len_r);
  // The burst ends at the first of wlast or beat len; any disagreement is a protocol error.
  assign w_final_s     = s_axi_wlast | w_beat_last_s;
  assign w_err_s       = w_err_r | (s_axi_wlast != w_beat_last_s);

  // Write FSM next state.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
      W_DATA: if (w_hs_s && w_final_s) w_state_s = W_RESP; else w_state_s = W_DATA;
      W_RESP: if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
      default: w_state_s = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state_r <= W_IDLE;
    else        w_state_r <= w_state_s;
  end

  // Write channel datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= 4'd0;
      w_id_r        <= 4'd0;
      w_idx_r       <= {IDX_W{1'b0}};
      w_len_r       <= 8'd0;
      w_cnt_r       <= 8'd0;
      w_err_r       <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            w_id_r        <= s_axi_awid;
            w_idx_r       <= word_idx(s_axi_awaddr);
            w_len_r       <= s_axi_awlen;
            w_cnt_r       <= 8'd0;
            w_err_r       <= (s_axi_awsize != AXI_AXSIZE);
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            if (w_final_s) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id_r;
              s_axi_bresp  <= w_err_s ? RESP_SLVERR : RESP_OKAY;
            end else begin
              w_idx_r <= w_idx_r + IDX_W'(1);
              w_cnt_r <= w_cnt_r + 8'd1;
              w_err_r <= w_err_s;
            end
          end
        end
        W_RESP: begin
          if (b_hs_s) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
          end
        end
        default: begin
          s_axi_wready <= 1'b0;
        end
      endcase
    end
  end

  r_state_t         r_state_r, r_state_s;
  logic [IDX_W-1:0] r_idx_r;
  logic [7:0]       r_len_r, r_cnt_r;
  logic             ar_hs_s, r_hs_s;
  logic             ram_re_s;
  logic [IDX_W-1:0] ram_raddr_s;

  assign ar_hs_s = s_axi_arvalid & s_axi_arready;
  assign r_hs_s  = s_axi_rvalid & s_axi_rready;

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
      R_DATA: if (r_hs_s && s_axi_rlast) r_state_s = R_IDLE; else r_state_s = R_DATA;
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read-port request: first word on AR, next word on each non-final beat accept.
  always_comb begin
    ram_re_s    = 1'b0;
    ram_raddr_s = r_idx_r + IDX_W'(1);
    if (r_state_r == R_IDLE) begin
      ram_re_s    = ar_hs_s;
      ram_raddr_s = word_idx(s_axi_araddr);
    end else begin
      ram_re_s    = r_hs_s & ~s_axi_rlast;
      ram_raddr_s = r_idx_r + IDX_W'(1);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state_r <= R_IDLE;
    else        r_state_r <= r_state_s;
  end

  // Read channel control and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= 4'd0;
      r_idx_r       <= {IDX_W{1'b0}};
      r_len_r       <= 8'd0;
      r_cnt_r       <= 8'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= (s_axi_arsize != AXI_AXSIZE) ? RESP_SLVERR : RESP_OKAY;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_len_r       <= s_axi_arlen;
            r_cnt_r       <= 8'd0;
            r_idx_r       <= word_idx(s_axi_araddr);
          end
        end
        R_DATA: begin
          if (r_hs_s) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
            end else begin
              r_cnt_r     <= r_cnt_r + 8'd1;
              r_idx_r     <= r_idx_r + IDX_W'(1);
              s_axi_rlast <= (r_cnt_r + 8'd1 == r_len_r);
            end
          end
        end
        default: begin
          s_axi_rvalid <= 1'b0;
        end
      endcase
    end
  end

  axi_ram_bytewe #(
    .DATA_W (AXI_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_hs_s),
    .waddr (w_idx_r),
    .wbe   (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (s_axi_rdata)
  );

endmodule
